// File: rtl/axil_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axil_rr_master_arbiter
// Description : Round-robin arbiter that shares one AXI4-Lite master port
//               between two simple register-access requesters. Only one
//               transaction is in flight at a time. Each accepted request
//               becomes a complete AXI4-Lite write or read. The completion
//               goes back only to the requester that issued it.
// Ports       : ACLK/ARESETN       - clock, synchronous active-low reset
//               req_*              - per-requester request (2 requesters)
//               rsp_*              - completion pulse, read data, response
//               busy               - transaction accepted and not yet done
//               M_AXI_*            - AXI4-Lite master interface
// Revision    : 1.0 - initial release
// ============================================================================
module axil_rr_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_we,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]            r_state,      w_state_nxt;
    logic                  r_last_grant, w_last_grant_nxt;
    logic                  r_grant,      w_grant_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,       w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,      w_wdata_nxt;
    logic                  r_awvalid,    w_awvalid_nxt;
    logic                  r_wvalid,     w_wvalid_nxt;
    logic                  r_bready,     w_bready_nxt;
    logic                  r_arvalid,    w_arvalid_nxt;
    logic                  r_rready,     w_rready_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata,  w_rsp_rdata_nxt;
    logic [1:0]            r_rsp_resp,   w_rsp_resp_nxt;

    logic                  w_gnt_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [1:0]            w_req_ready;

    // Round-robin pick: on contention the requester that did not win last
    // time gets the grant; otherwise whichever one is asking.
    assign w_gnt_idx   = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    assign w_sel_addr  = w_gnt_idx ? req_addr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                                   : req_addr[ADDR_WIDTH-1:0];
    assign w_sel_wdata = w_gnt_idx ? req_wdata[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                   : req_wdata[DATA_WIDTH-1:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_awvalid_nxt    = r_awvalid;
        w_wvalid_nxt     = r_wvalid;
        w_bready_nxt     = r_bready;
        w_arvalid_nxt    = r_arvalid;
        w_rready_nxt     = r_rready;
        w_rsp_rdata_nxt  = r_rsp_rdata;
        w_rsp_resp_nxt   = r_rsp_resp;
        w_req_ready      = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_req_ready[w_gnt_idx] = 1'b1;
                    w_grant_nxt            = w_gnt_idx;
                    w_last_grant_nxt       = w_gnt_idx;
                    w_addr_nxt             = w_sel_addr;
                    w_wdata_nxt            = w_sel_wdata;
                    if (req_we[w_gnt_idx]) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = S_WR_REQ;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                // AW and W retire independently; a VALID that is already low
                // means that channel has finished its handshake.
                if (r_awvalid && M_AXI_AWREADY) w_awvalid_nxt = 1'b0;
                if (r_wvalid  && M_AXI_WREADY)  w_wvalid_nxt  = 1'b0;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID && r_bready) begin
                    w_rsp_resp_nxt  = M_AXI_BRESP;
                    w_rsp_rdata_nxt = '0;
                    w_bready_nxt    = 1'b0;
                    w_state_nxt     = S_DONE;
                end
            end
            S_RD_REQ: begin
                if (r_arvalid && M_AXI_ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (M_AXI_RVALID && r_rready) begin
                    w_rsp_rdata_nxt = M_AXI_RDATA;
                    w_rsp_resp_nxt  = M_AXI_RRESP;
                    w_rready_nxt    = 1'b0;
                    w_state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_resp   <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_rsp_resp   <= w_rsp_resp_nxt;
        end
    end

    // The accept pulse is combinational from req_valid, so it is masked while
    // reset is asserted to keep every output quiet during reset.
    assign req_ready     = w_req_ready & {2{ARESETN}};
    assign busy          = (r_state != S_IDLE) || (|req_ready);
    assign rsp_valid     = (r_state == S_DONE) ? {r_grant, ~r_grant} : 2'b00;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_rr_master_arbiter
// Description : Directed self-checking bench for axil_rr_master_arbiter with
//               a small AXI4-Lite slave model (4 x 32-bit registers, SLVERR
//               above 0xC, controllable AWREADY/WREADY and read hold-off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_rr_master_arbiter;

    logic        ACLK;
    logic        ARESETN;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    logic        awready_en, wready_en, hold_r;
    int          n_cmp, n_err;

    axil_rr_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:3];
    logic        aw_got, w_got;
    logic [31:0] aw_addr_l, w_data_l;

    assign awready = awready_en;
    assign wready  = wready_en;
    assign arready = 1'b1;

    always @(posedge ACLK) begin : slv
        logic        ag, wg;
        logic [31:0] a, d;
        if (!ARESETN) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            bresp  <= 2'b00;
            rresp  <= 2'b00;
            rdata  <= 32'h0;
        end else begin
            ag = aw_got; a = aw_addr_l;
            wg = w_got;  d = w_data_l;
            if (awvalid && awready) begin ag = 1'b1; a = awaddr; end
            if (wvalid && wready)   begin wg = 1'b1; d = wdata;  end
            if (bvalid && bready) bvalid <= 1'b0;
            if (ag && wg) begin
                if (a < 32'h10) mem[a[3:2]] <= d;
                bresp  <= (a < 32'h10) ? 2'b00 : 2'b10;
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got    <= ag;
                w_got     <= wg;
                aw_addr_l <= a;
                w_data_l  <= d;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready && !hold_r) begin
                rvalid <= 1'b1;
                rdata  <= (araddr < 32'h10) ? mem[araddr[3:2]] : 32'h0;
                rresp  <= 2'b00;
            end
        end
    end

    // Issue one request from requester r and wait for its completion.
    // lat = cycles from the grant cycle to the rsp_valid cycle, -1 on timeout.
    task automatic run_txn(input int r, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, output logic [1:0] rv,
                           output logic [31:0] rd, output logic [1:0] rr,
                           output int lat);
        bit got;
        @(posedge ACLK); #1;
        req_valid[r] = 1'b1;
        req_we[r]    = we;
        req_addr[r*32 +: 32]  = addr;
        req_wdata[r*32 +: 32] = data;
        got = 1'b0;
        lat = -1; rv = 2'b00; rd = 32'h0; rr = 2'b00;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge ACLK);
            if (req_ready[r]) got = 1'b1;
        end
        @(posedge ACLK); #1;
        req_valid[r] = 1'b0;
        if (got) begin
            for (int k = 1; k <= 20 && lat < 0; k++) begin
                @(negedge ACLK);
                if (rsp_valid != 2'b00) begin
                    lat = k; rv = rsp_valid; rd = rsp_rdata; rr = rsp_resp;
                end
            end
        end
    endtask

    task automatic test_reset;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            n_err++; $display("FAIL reset_axi_vr: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        n_cmp++;
        if ({busy, req_ready, rsp_valid} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, req_ready, rsp_valid});
        end
        n_cmp++;
        if ({rsp_rdata, rsp_resp} !== 34'h0) begin
            n_err++; $display("FAIL reset_rsp: got %h want 0", {rsp_rdata, rsp_resp});
        end
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        n_cmp++;
        if ({awprot, arprot, wstrb} !== {3'b000, 3'b000, 4'hF}) begin
            n_err++; $display("FAIL const_prot_strb: got %h want 00f", {awprot, arprot, wstrb});
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_write0;
        @(posedge ACLK); #1;
        req_valid = 2'b01; req_we = 2'b01;
        req_addr[31:0] = 32'h0; req_wdata[31:0] = 32'h0101FFFF;
        @(negedge ACLK);                       // cycle N
        n_cmp++;
        if ({req_ready, busy} !== 3'b011) begin
            n_err++; $display("FAIL wr0_grant: got %b want 011", {req_ready, busy});
        end
        @(posedge ACLK); #1; req_valid = 2'b00;
        @(negedge ACLK);                       // N+1
        n_cmp++;
        if ({awvalid, wvalid, bready, req_ready} !== 5'b11000) begin
            n_err++; $display("FAIL wr0_awv_wv: got %b want 11000", {awvalid, wvalid, bready, req_ready});
        end
        n_cmp++;
        if ({awaddr, wdata} !== {32'h0, 32'h0101FFFF}) begin
            n_err++; $display("FAIL wr0_addr_data: got %h want 000000000101ffff", {awaddr, wdata});
        end
        @(negedge ACLK);                       // N+2
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            n_err++; $display("FAIL wr0_bready: got %b want 001", {awvalid, wvalid, bready});
        end
        @(negedge ACLK);                       // N+3
        n_cmp++;
        if ({rsp_valid, rsp_resp, busy, bready} !== 6'b010010) begin
            n_err++; $display("FAIL wr0_rsp: got %b want 010010", {rsp_valid, rsp_resp, busy, bready});
        end
        n_cmp++;
        if (rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL wr0_rdata: got %h want 0", rsp_rdata);
        end
        @(negedge ACLK);                       // N+4
        n_cmp++;
        if ({rsp_valid, busy} !== 3'b000) begin
            n_err++; $display("FAIL wr0_after: got %b want 000", {rsp_valid, busy});
        end
    endtask

    task automatic test_read1;
        logic [1:0] rv, rr; logic [31:0] rd; int lat;
        run_txn(0, 1'b1, 32'h4, 32'hABCD0001, rv, rd, rr, lat);
        n_cmp++;
        if ({rv, rr} !== 4'b0100 || lat !== 3) begin
            n_err++; $display("FAIL rd1_prewrite: got rv=%b rr=%b lat=%0d want 01 00 3", rv, rr, lat);
        end
        run_txn(1, 1'b0, 32'h4, 32'h0, rv, rd, rr, lat);
        n_cmp++;
        if ({rv, rr} !== 4'b1000 || lat !== 3) begin
            n_err++; $display("FAIL rd1_rsp: got rv=%b rr=%b lat=%0d want 10 00 3", rv, rr, lat);
        end
        n_cmp++;
        if (rd !== 32'hABCD0001) begin
            n_err++; $display("FAIL rd1_data: got %h want abcd0001", rd);
        end
    endtask

    task automatic test_back_to_back;
        int          idx [2];
        int          gord [$];
        int          gcyc [$];
        logic [1:0]  rvs [$];
        logic [31:0] rds [$];
        idx[0] = 0; idx[1] = 0;
        for (int c = 0; c < 40 && rvs.size() < 4; c++) begin
            @(posedge ACLK); #1;
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = (idx[i] < 2);
                req_we[i]    = (idx[i] == 0);
                req_addr[i*32 +: 32]  = (i == 0) ? 32'h8 : 32'hC;
                req_wdata[i*32 +: 32] = (i == 0) ? 32'hDEAD0011 : 32'hBEEF0011;
            end
            @(negedge ACLK);
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    gord.push_back(i); gcyc.push_back(c); idx[i]++;
                end
            end
            if (rsp_valid != 2'b00) begin
                rvs.push_back(rsp_valid); rds.push_back(rsp_rdata);
            end
        end
        @(posedge ACLK); #1; req_valid = 2'b00;
        n_cmp++;
        if (gord.size() !== 4 || rvs.size() !== 4) begin
            n_err++; $display("FAIL b2b_count: got grants=%0d rsps=%0d want 4 4", gord.size(), rvs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (gord[k] !== (k % 2)) begin
                    n_err++; $display("FAIL b2b_grant%0d: got %0d want %0d", k, gord[k], k % 2);
                end
                n_cmp++;
                if (rvs[k] !== ((k % 2) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL b2b_rspv%0d: got %b want %b", k, rvs[k], (k % 2) ? 2'b10 : 2'b01);
                end
            end
            n_cmp++;
            if (rds[2] !== 32'hDEAD0011) begin
                n_err++; $display("FAIL b2b_rd0: got %h want dead0011", rds[2]);
            end
            n_cmp++;
            if (rds[3] !== 32'hBEEF0011) begin
                n_err++; $display("FAIL b2b_rd1: got %h want beef0011", rds[3]);
            end
            n_cmp++;
            if (gcyc[1] - gcyc[0] !== 4) begin
                n_err++; $display("FAIL b2b_spacing: got %0d want 4", gcyc[1] - gcyc[0]);
            end
        end
    endtask

    task automatic test_wr_skew;
        awready_en = 1'b0;
        @(posedge ACLK); #1;
        req_valid = 2'b01; req_we = 2'b01;
        req_addr[31:0] = 32'h0; req_wdata[31:0] = 32'h12345678;
        @(negedge ACLK);                       // N grant
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL skew_grant: got %b want 01", req_ready);
        end
        @(posedge ACLK); #1; req_valid = 2'b00;
        @(negedge ACLK);                       // N+1 W handshake
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b110) begin
            n_err++; $display("FAIL skew_n1: got %b want 110", {awvalid, wvalid, bready});
        end
        for (int k = 2; k <= 3; k++) begin
            @(negedge ACLK);                   // N+2, N+3 AW waiting
            n_cmp++;
            if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 32'h0) begin
                n_err++; $display("FAIL skew_wait%0d: got %b addr %h want 100 0", k, {awvalid, wvalid, bready}, awaddr);
            end
        end
        @(posedge ACLK); #1; awready_en = 1'b1;
        @(negedge ACLK);                       // N+4 AW handshake
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b100) begin
            n_err++; $display("FAIL skew_n4: got %b want 100", {awvalid, wvalid, bready});
        end
        @(negedge ACLK);                       // N+5 B
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            n_err++; $display("FAIL skew_n5: got %b want 001", {awvalid, wvalid, bready});
        end
        @(negedge ACLK);                       // N+6 completion
        n_cmp++;
        if ({rsp_valid, rsp_resp} !== 4'b0100) begin
            n_err++; $display("FAIL skew_rsp: got %b want 0100", {rsp_valid, rsp_resp});
        end
    endtask

    task automatic test_slverr;
        logic [1:0] rv, rr; logic [31:0] rd; int lat;
        run_txn(1, 1'b1, 32'h10, 32'hCAFE0000, rv, rd, rr, lat);
        n_cmp++;
        if ({rv, rr} !== 4'b1010 || lat !== 3 || rd !== 32'h0) begin
            n_err++; $display("FAIL slverr_rsp: got rv=%b rr=%b rd=%h lat=%0d want 10 10 0 3", rv, rr, rd, lat);
        end
        @(negedge ACLK);
        n_cmp++;
        if ({rsp_valid, rsp_resp} !== 4'b0010) begin
            n_err++; $display("FAIL slverr_hold: got %b want 0010", {rsp_valid, rsp_resp});
        end
        run_txn(0, 1'b0, 32'h0, 32'h0, rv, rd, rr, lat);
        n_cmp++;
        if ({rv, rr} !== 4'b0100 || lat !== 3 || rd !== 32'h12345678) begin
            n_err++; $display("FAIL slverr_next: got rv=%b rr=%b rd=%h lat=%0d want 01 00 12345678 3", rv, rr, rd, lat);
        end
    endtask

    task automatic test_reset_mid;
        logic [1:0]  rvs [$];
        logic [31:0] rds [$];
        bit          g1;
        hold_r = 1'b1;
        @(posedge ACLK); #1;
        req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h0;
        @(negedge ACLK);                       // N grant (last_grant -> 0)
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL rst_mid_grant: got %b want 01", req_ready);
        end
        @(posedge ACLK); #1; req_valid = 2'b00;
        @(negedge ACLK);                       // N+1 AR
        @(negedge ACLK);                       // N+2 RD_RESP
        n_cmp++;
        if ({arvalid, rready, busy} !== 3'b011) begin
            n_err++; $display("FAIL rst_mid_rdresp: got %b want 011", {arvalid, rready, busy});
        end
        @(posedge ACLK); #1; ARESETN = 1'b0;
        @(negedge ACLK);
        @(posedge ACLK); #1; ARESETN = 1'b1; hold_r = 1'b0;
        @(negedge ACLK);
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, rsp_valid} !== 8'b0) begin
            n_err++; $display("FAIL rst_mid_clear: got %b want 00000000", {awvalid, wvalid, bready, arvalid, rready, busy, rsp_valid});
        end
        @(posedge ACLK); #1;
        req_valid = 2'b11; req_we = 2'b00;
        req_addr = {32'h4, 32'h0};
        @(negedge ACLK);
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL rst_mid_rr: got %b want 01", req_ready);
        end
        @(posedge ACLK); #1; req_valid[0] = 1'b0;
        g1 = 1'b0;
        for (int c = 0; c < 20 && rvs.size() < 2; c++) begin
            @(negedge ACLK);
            if (req_ready[1]) g1 = 1'b1;
            if (rsp_valid != 2'b00) begin
                rvs.push_back(rsp_valid); rds.push_back(rsp_rdata);
            end
            @(posedge ACLK); #1;
            if (g1) req_valid[1] = 1'b0;
        end
        req_valid = 2'b00;
        n_cmp++;
        if (rvs.size() !== 2) begin
            n_err++; $display("FAIL rst_mid_count: got %0d want 2", rvs.size());
        end else begin
            n_cmp++;
            if (rvs[0] !== 2'b01 || rds[0] !== 32'h12345678) begin
                n_err++; $display("FAIL rst_mid_r0: got %b %h want 01 12345678", rvs[0], rds[0]);
            end
            n_cmp++;
            if (rvs[1] !== 2'b10 || rds[1] !== 32'hABCD0001) begin
                n_err++; $display("FAIL rst_mid_r1: got %b %h want 10 abcd0001", rvs[1], rds[1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        ARESETN = 1'b0;
        req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        awready_en = 1'b1; wready_en = 1'b1; hold_r = 1'b0;
        test_reset();
        test_write0();
        test_read1();
        test_back_to_back();
        test_wr_skew();
        test_slverr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_rr_master_arbiter.md
Name: axil_rr_master_arbiter

Overview:
- Shares one AXI4-Lite master port between two simple register-access requesters.
- Typical requesters: a PS-side configuration path and a PL-side FNN control sequencer. The shared target is the myip slave register bank (4 x 32-bit registers, word addresses 0x0/0x4/0x8/0xC).
- Arbitration is round-robin, one outstanding transaction at a time.
- Each request becomes a full AXI4-Lite write or read. The response is returned only to the requester that issued it.

Parameters:
- ADDR_WIDTH, 32, request and AXI address width
- DATA_WIDTH, 32, request and AXI data width (WSTRB width = DATA_WIDTH/8)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester one-cycle accept pulse
- req_we  in  2  1 = write, 0 = read, per requester
- req_addr  in  2*ADDR_WIDTH  packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  packed, same layout
- rsp_valid  out  2  one-cycle completion pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid, 0 for writes
- rsp_resp  out  2  AXI BRESP/RRESP of the completed transaction
- busy  out  1  high from accept through the rsp_valid cycle
- M_AXI_AWADDR/AWPROT/AWVALID, AWREADY  out ADDR_WIDTH/3/1, in 1  write address channel
- M_AXI_WDATA/WSTRB/WVALID, WREADY  out DATA_WIDTH/DATA_WIDTH/8/1, in 1  write data channel
- M_AXI_BRESP, BVALID  in 2/1; M_AXI_BREADY out 1  write response channel
- M_AXI_ARADDR/ARPROT/ARVALID, ARREADY  out ADDR_WIDTH/3/1, in 1  read address channel
- M_AXI_RDATA, RRESP, RVALID  in DATA_WIDTH/2/1; M_AXI_RREADY out 1  read data channel

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge):
  - state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first contention.
  - Reset mid-transaction drops all VALID/READY outputs on the next edge and issues no rsp_valid.
- AWPROT=ARPROT=3'b000 and WSTRB=all ones, constant.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - If exactly one req_valid is set, grant it. If both are set, grant !last_grant.
  - Grant cycle: pulse req_ready[g]; latch we/addr/wdata and g; last_grant<=g.
  - Next state is WR_REQ if we=1, else RD_REQ.
  - No req_ready is issued outside IDLE.
- WR_REQ:
  - AWVALID and WVALID both assert the cycle after the grant.
  - Each VALID drops the cycle after its own handshake (VALID&READY). AW and W complete independently, in either order or together.
  - Go to WR_RESP once both have completed; BREADY asserts in WR_RESP.
  - Address and data are held stable while their VALID is high.
- WR_RESP: on BVALID&BREADY, capture BRESP, drop BREADY, go to DONE.
- RD_REQ: assert ARVALID; on ARVALID&ARREADY drop it and go to RD_RESP with RREADY=1.
- RD_RESP: on RVALID&RREADY, capture RDATA and RRESP, drop RREADY, go to DONE.
- DONE:
  - Pulse rsp_valid[g] for one cycle with rsp_rdata/rsp_resp; return to IDLE.
  - rsp_rdata and rsp_resp hold their values until the next DONE.
- Minimum latency with zero-wait slave (READY already high):
  - grant at cycle N; AW/W handshake N+1; B N+2; rsp_valid N+3.
  - Read: AR N+1, R N+2, rsp_valid N+3.
- Throughput: a new grant is possible in the cycle after DONE (IDLE one cycle). Peak rate is one transaction per 4 cycles.
- Non-OKAY responses (SLVERR 2'b10, DECERR 2'b11) are forwarded unchanged. The FSM does not retry and does not stall.
- A requester dropping req_valid before its grant is legal and ignored. After req_ready, the request is committed.
- No timeout: a slave that never responds hangs the FSM; busy remains high.

Test Plan:
- Req0 writes 0x0101FFFF to addr 0x0, zero-wait slave -> AWVALID/WVALID at N+1, BREADY at N+2, rsp_valid=2'b01 at N+3, rsp_resp=2'b00, rsp_rdata=0.
- Req1 reads addr 0x4 after 0xABCD0001 was written there -> rsp_valid=2'b10, rsp_rdata=0xABCD0001, rsp_resp=2'b00.
- Both requesters hold req_valid for 4 transactions (writes 0xDEAD0011/0xBEEF0011 to 0x8/0xC, then reads) -> grants alternate 0,1,0,1 and readback data matches.
- Slave asserts WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID holds, and BREADY rises only after both handshakes complete.
- Slave returns BRESP=2'b10 on a write to 0x10 -> rsp_resp=2'b10 to that requester and the next request proceeds normally.
- ARESETN low for one cycle while in RD_RESP -> all M_AXI VALID/READY outputs 0, busy 0, no rsp_valid, and the next grant goes to requester 0 if both request.
